wakeup_broadcast_unit: RTL and testbench
========================================

WAKEUP_BROADCAST_UNIT -- requirements
Module: wakeup_broadcast_unit

Interface
REQ-001 Parameter LANE_NUM, default WAKEUP_WIDTH, number of independent issue/wakeup lanes.
REQ-002 Parameter REG_NUM_BIT_WIDTH, default 5, physical register number width.
REQ-003 Parameter MAX_LATENCY, default 4, largest legal issue-to-wakeup latency in cycles (>=1).
REQ-004 clk  in  1  clock; reset rst, synchronous, active-high.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 stall  in  1  freezes all lane state while high.
REQ-007 flush  in  1  discards every in-flight wakeup.
REQ-008 issue  in  1 per lane  issue request.
REQ-009 issueDstValid  in  1 per lane  op writes a destination register.
REQ-010 issueDstRegNum  in  REG_NUM_BIT_WIDTH per lane  destination physical register.
REQ-011 issueLatency  in  LAT_W = $clog2(MAX_LATENCY+1) per lane  cycles from acceptance to wakeup.
REQ-012 issueGrant  out  1 per lane  combinational; request accepted this cycle.
REQ-013 wakeup  out  1 per lane  wakeup broadcast valid.
REQ-014 wakeupDstValid  out  1 per lane  broadcast carries a destination.
REQ-015 wakeupDstRegNum  out  REG_NUM_BIT_WIDTH per lane  broadcast register number.

Function
REQ-016 Each lane SHALL hold MAX_LATENCY slots; slot[i] holds the entry due i+1 cycles after the current cycle; entry = {valid, dstValid, regNum}.
REQ-017 wakeup, wakeupDstValid, wakeupDstRegNum SHALL be driven directly from slot[0] (wakeup = slot[0].valid, others zero when invalid); no combinational path from inputs.
REQ-018 When not stalled, each cycle slot[i] <= slot[i+1], top slot <= invalid, slot[0] retires.
REQ-019 issueGrant SHALL be 1 iff issue && !stall && !flush && !rst && 1<=issueLatency<=MAX_LATENCY && (issueLatency==MAX_LATENCY || !slot[issueLatency].valid).
REQ-020 Granted request at cycle t with latency L SHALL be written to slot[L-1] at t+1 and appear on wakeup exactly in cycle t+L, for one cycle.
REQ-021 A rejected request SHALL not modify state; the issuer retries; latency 0 or >MAX_LATENCY is always rejected.
REQ-022 During stall: no shift, no writes, outputs hold slot[0]; wakeup SHALL be gated to 0 while stall is high, and slot[0] is re-presented after stall drops.
REQ-023 flush SHALL invalidate all slots of all lanes at the next edge, overriding stall; wakeup is not gated in the flush cycle itself.
REQ-024 Lanes are independent; equal regNum on two lanes in one cycle is legal and broadcast on both.

Reset
REQ-025 rst SHALL invalidate all slots; during and after the reset cycle wakeup=0, wakeupDstValid=0, wakeupDstRegNum=0, issueGrant=0.
REQ-026 rst asserted mid-operation SHALL discard all in-flight entries with no wakeup emitted afterwards; rst has priority over flush and stall.

Configuration
REQ-027 Macro WAKEUP_CONFLICT_STATS_EN: when defined, add output conflictCount (16 bits) counting cycles with any lane issue && !grant && !stall && !flush, saturating at 0xFFFF, cleared by rst; when undefined, port and counter are absent and behaviour is otherwise identical.

Structure
REQ-028 WakeupSlotEntry typedef and the LAT_W-derived latency type SHALL live in SchedulerTypes; MAX_LATENCY default lives there as a constant.
REQ-029 One sub-module WakeupLaneShifter (single-lane slot array, grant logic) SHALL be instantiated LANE_NUM times.

Verification
REQ-030 Lane0 issue L=3 reg 7 at t=10 -> grant=1; wakeup lane0 only at t=13 with regNum 7, dstValid 1.
REQ-031 Lane0 L=3 at t=10, then L=2 at t=11 -> second grant=0 (slot[2] occupied); retry L=1 at t=11 accepted, wakeup at t=12 and t=13.
REQ-032 L=2 at t=10, stall t=11..12 -> wakeup 0 during stall, wakeup at t=14.
REQ-033 L=4 on both lanes at t=5, flush at t=7 -> no wakeup ever; grant=0 at t=7.
REQ-034 issueLatency 0 and 5 (MAX=4) -> grant=0, no state change; with WAKEUP_CONFLICT_STATS_EN conflictCount increments by 2.
REQ-035 rst at t=3 with entries in flight -> all outputs 0 from t=4, no later wakeup.

Source files
------------

// File: rtl/wakeup_broadcast_unit_pkg.sv
// Shared scheduler types: wakeup slot entry, latency type and default sizing.
// Included by wakeup_broadcast_unit and WakeupLaneShifter.
package SchedulerTypes;

  localparam int unsigned WAKEUP_WIDTH        = 2;
  localparam int unsigned MAX_LATENCY_DEFAULT = 4;
  localparam int unsigned REG_NUM_W_DEFAULT   = 5;
  localparam int unsigned REG_NUM_W_MAX       = 16;
  localparam int unsigned LAT_W_DEFAULT       = $clog2(MAX_LATENCY_DEFAULT + 1);

  typedef logic [LAT_W_DEFAULT-1:0] WakeupLatency;

  // regNum is sized for the widest supported register file; lanes use the low bits.
  typedef struct packed {
    logic                     valid;
    logic                     dstValid;
    logic [REG_NUM_W_MAX-1:0] regNum;
  } WakeupSlotEntry;

  function automatic WakeupSlotEntry makeEntry(input logic dstValid,
                                               input logic [REG_NUM_W_MAX-1:0] regNum);
    WakeupSlotEntry e;
    e.valid    = 1'b1;
    e.dstValid = dstValid;
    e.regNum   = regNum;
    return e;
  endfunction

endpackage

// File: rtl/wakeup_broadcast_unit_lane.sv
// WakeupLaneShifter: one lane's delay line of wakeup slots plus its issue-grant check.
// slot[i] holds the entry due i+1 cycles from now; slot[0] drives the broadcast.
module WakeupLaneShifter
  import SchedulerTypes::*;
#(
  parameter int unsigned REG_NUM_BIT_WIDTH = REG_NUM_W_DEFAULT,
  parameter int unsigned MAX_LATENCY       = MAX_LATENCY_DEFAULT,
  parameter int unsigned LAT_W             = $clog2(MAX_LATENCY + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         flush,
  input  logic                         issue,
  input  logic                         issueDstValid,
  input  logic [REG_NUM_BIT_WIDTH-1:0] issueDstRegNum,
  input  logic [LAT_W-1:0]             issueLatency,
  output logic                         issueGrant,
  output logic                         wakeup,
  output logic                         wakeupDstValid,
  output logic [REG_NUM_BIT_WIDTH-1:0] wakeupDstRegNum
);

  WakeupSlotEntry slot [MAX_LATENCY];
  WakeupSlotEntry newEntry;
  logic           latInRange;
  logic           targetFree;

  assign latInRange = (issueLatency != '0) && (issueLatency <= LAT_W'(MAX_LATENCY));
  assign newEntry   = makeEntry(issueDstValid, REG_NUM_W_MAX'(issueDstRegNum));

  // The entry in slot[L] would land in slot[L-1] on the same edge; the top slot
  // always drains, so latency MAX_LATENCY never collides.
  always_comb begin
    targetFree = 1'b1;
    for (int unsigned i = 1; i < MAX_LATENCY; i++) begin
      if (issueLatency == LAT_W'(i)) targetFree = !slot[i].valid;
    end
  end

  assign issueGrant = issue && !stall && !flush && !rst && latInRange && targetFree;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int unsigned i = 0; i < MAX_LATENCY; i++) slot[i] <= '0;
    end else if (!stall) begin
      for (int unsigned i = 0; i + 1 < MAX_LATENCY; i++) slot[i] <= slot[i+1];
      slot[MAX_LATENCY-1] <= '0;
      for (int unsigned i = 0; i < MAX_LATENCY; i++) begin
        if (issueGrant && issueLatency == LAT_W'(i + 1)) slot[i] <= newEntry;
      end
    end
  end

  assign wakeup          = slot[0].valid && !stall && !rst;
  assign wakeupDstValid  = slot[0].valid && slot[0].dstValid && !rst;
  assign wakeupDstRegNum = (slot[0].valid && !rst) ? slot[0].regNum[REG_NUM_BIT_WIDTH-1:0] : '0;

endmodule

// File: rtl/wakeup_broadcast_unit.sv
// Multi-lane wakeup broadcast: LANE_NUM independent WakeupLaneShifter instances.
// Optional WAKEUP_CONFLICT_STATS_EN adds a saturating conflictCount output.
module wakeup_broadcast_unit
  import SchedulerTypes::*;
#(
  parameter int unsigned LANE_NUM          = WAKEUP_WIDTH,
  parameter int unsigned REG_NUM_BIT_WIDTH = REG_NUM_W_DEFAULT,
  parameter int unsigned MAX_LATENCY       = MAX_LATENCY_DEFAULT,
  parameter int unsigned LAT_W             = $clog2(MAX_LATENCY + 1)
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        stall,
  input  logic                                        flush,
  input  logic [LANE_NUM-1:0]                         issue,
  input  logic [LANE_NUM-1:0]                         issueDstValid,
  input  logic [LANE_NUM-1:0][REG_NUM_BIT_WIDTH-1:0]  issueDstRegNum,
  input  logic [LANE_NUM-1:0][LAT_W-1:0]              issueLatency,
  output logic [LANE_NUM-1:0]                         issueGrant,
  output logic [LANE_NUM-1:0]                         wakeup,
  output logic [LANE_NUM-1:0]                         wakeupDstValid,
  output logic [LANE_NUM-1:0][REG_NUM_BIT_WIDTH-1:0]  wakeupDstRegNum
`ifdef WAKEUP_CONFLICT_STATS_EN
  ,
  output logic [15:0]                                 conflictCount
`endif
);

  for (genvar l = 0; l < LANE_NUM; l++) begin : gLane
    WakeupLaneShifter #(
      .REG_NUM_BIT_WIDTH(REG_NUM_BIT_WIDTH),
      .MAX_LATENCY      (MAX_LATENCY),
      .LAT_W            (LAT_W)
    ) uLane (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .flush          (flush),
      .issue          (issue[l]),
      .issueDstValid  (issueDstValid[l]),
      .issueDstRegNum (issueDstRegNum[l]),
      .issueLatency   (issueLatency[l]),
      .issueGrant     (issueGrant[l]),
      .wakeup         (wakeup[l]),
      .wakeupDstValid (wakeupDstValid[l]),
      .wakeupDstRegNum(wakeupDstRegNum[l])
    );
  end

`ifdef WAKEUP_CONFLICT_STATS_EN
  logic anyConflict;

  assign anyConflict = (|(issue & ~issueGrant)) && !stall && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      conflictCount <= '0;
    end else if (anyConflict && conflictCount != '1) begin
      conflictCount <= conflictCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wakeup_broadcast_unit.sv
// Self-checking bench for wakeup_broadcast_unit: directed scenarios then random
// traffic, compared against a pending-event list model per lane.
module tb_wakeup_broadcast_unit;
  import SchedulerTypes::*;

  localparam int LN = 2;
  localparam int RW = 5;
  localparam int ML = 4;
  localparam int LW = $clog2(ML + 1);

  logic clk = 1'b0;
  logic rst, stall, flush;
  logic [LN-1:0]         issue, issueDstValid, issueGrant, wakeup, wakeupDstValid;
  logic [LN-1:0][RW-1:0] issueDstRegNum, wakeupDstRegNum;
  logic [LN-1:0][LW-1:0] issueLatency;
`ifdef WAKEUP_CONFLICT_STATS_EN
  logic [15:0] conflictCount;
  int          expConf = 0;
`endif

  always #5 clk = ~clk;

  wakeup_broadcast_unit #(
    .LANE_NUM         (LN),
    .REG_NUM_BIT_WIDTH(RW),
    .MAX_LATENCY      (ML)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .issue          (issue),
    .issueDstValid  (issueDstValid),
    .issueDstRegNum (issueDstRegNum),
    .issueLatency   (issueLatency),
    .issueGrant     (issueGrant),
    .wakeup         (wakeup),
    .wakeupDstValid (wakeupDstValid),
    .wakeupDstRegNum(wakeupDstRegNum)
`ifdef WAKEUP_CONFLICT_STATS_EN
    ,
    .conflictCount  (conflictCount)
`endif
  );

  // A pending wakeup: k = number of unstalled edges before it is broadcast.
  typedef struct {
    int          k;
    logic        dv;
    logic [RW-1:0] rn;
  } PendT;

  PendT pend [LN][$];
  int   total = 0;
  int   bad   = 0;
  int   wakeCount = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    issue = '0; issueDstValid = '0; issueDstRegNum = '0; issueLatency = '0;
    stall = 1'b0; flush = 1'b0; rst = 1'b0;
  endtask

  task automatic req(input int l, input int lat, input int rn);
    issue[l] = 1'b1; issueDstValid[l] = 1'b1;
    issueDstRegNum[l] = RW'(rn); issueLatency[l] = LW'(lat);
  endtask

  // Checks the current cycle against the model, crosses one clock edge, updates the model.
  task automatic step(input string name);
    logic [LN-1:0] eg;
    PendT          nq[$];
    PendT          p;
    logic          found, dv, anyConf;
    logic [RW-1:0] rn;
    int            lat;
    #1;
    anyConf = 1'b0;
    for (int l = 0; l < LN; l++) begin
      found = 1'b0; dv = 1'b0; rn = '0;
      foreach (pend[l][i]) if (pend[l][i].k == 0) begin
        found = 1'b1; dv = pend[l][i].dv; rn = pend[l][i].rn;
      end
      lat = int'(issueLatency[l]);
      eg[l] = issue[l] && !stall && !flush && !rst && lat >= 1 && lat <= ML;
      foreach (pend[l][i]) if (pend[l][i].k == lat) eg[l] = 1'b0;
      if (issue[l] && !eg[l]) anyConf = 1'b1;
      check($sformatf("%s.grant%0d", name, l), 32'(issueGrant[l]), 32'(eg[l]));
      check($sformatf("%s.wakeup%0d", name, l), 32'(wakeup[l]), 32'(found && !stall && !rst));
      check($sformatf("%s.dstValid%0d", name, l), 32'(wakeupDstValid[l]), 32'(found && dv && !rst));
      check($sformatf("%s.regNum%0d", name, l), 32'(wakeupDstRegNum[l]),
            (found && !rst) ? 32'(rn) : 32'd0);
      if (found && !stall && !rst) wakeCount++;
    end
`ifdef WAKEUP_CONFLICT_STATS_EN
    check($sformatf("%s.conflictCount", name), 32'(conflictCount), 32'(expConf));
    if (rst) expConf = 0;
    else if (anyConf && !stall && !flush && expConf < 65535) expConf++;
`endif
    @(posedge clk);
    for (int l = 0; l < LN; l++) begin
      if (rst || flush) begin
        pend[l] = {};
      end else if (!stall) begin
        nq = {};
        foreach (pend[l][i]) if (pend[l][i].k != 0) begin
          p = pend[l][i]; p.k--; nq.push_back(p);
        end
        if (eg[l]) begin
          p.k = int'(issueLatency[l]) - 1; p.dv = issueDstValid[l]; p.rn = issueDstRegNum[l];
          nq.push_back(p);
        end
        pend[l] = nq;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int wcBefore;
    idle();
    @(negedge clk);

    // Reset state, including a stray request during reset.
    rst = 1'b1; req(0, 2, 3); step("rst0");
    idle(); rst = 1'b1; step("rst1");
    idle(); step("postRst");

    // Single issue, L=3, reg 7 on lane 0.
    req(0, 3, 7); step("L3issue");
    idle();
    for (int i = 0; i < 4; i++) step("L3wait");

    // Back-to-back: L=3 then L=2 collides; L=1 in the same cycle is accepted.
    req(0, 3, 9); step("colA");
    req(0, 2, 10); #1;
    check("colRejectL2", 32'(issueGrant[0]), 32'd0);
    issueLatency[0] = LW'(1); issueDstRegNum[0] = RW'(11);
    step("colRetryL1");
    idle();
    for (int i = 0; i < 4; i++) step("colWait");

    // Stall holds and gates the broadcast.
    req(0, 2, 12); step("stIssue");
    idle(); stall = 1'b1; req(1, 1, 4); step("st1");
    stall = 1'b1; step("st2");
    idle();
    for (int i = 0; i < 4; i++) step("stWait");

    // Flush discards in-flight entries on both lanes.
    wcBefore = wakeCount;
    req(0, 4, 20); req(1, 4, 21); step("flIssue");
    idle(); step("flMid");
    flush = 1'b1; req(1, 1, 22); step("flush");
    idle();
    for (int i = 0; i < 6; i++) step("flWait");
    check("flushNoWake", 32'(wakeCount - wcBefore), 32'd0);

    // Illegal latencies are rejected.
    req(0, 0, 1); req(1, 5, 2); step("badLat");
    idle(); req(0, 5, 3); step("badLat2");
    idle(); step("badLatIdle");

    // Same register on both lanes, then L=MAX behind a full pipe.
    req(0, 1, 13); req(1, 1, 13); step("sameReg");
    req(0, 4, 14); step("max1");
    req(0, 4, 15); step("max2");
    idle();
    for (int i = 0; i < 5; i++) step("maxWait");

    // Reset mid-flight discards everything.
    wcBefore = wakeCount;
    req(0, 3, 16); req(1, 4, 17); step("rstIssue");
    idle(); stall = 1'b1; flush = 1'b1; rst = 1'b1; step("rstMid");
    idle();
    for (int i = 0; i < 6; i++) step("rstWait");
    check("rstNoWake", 32'(wakeCount - wcBefore), 32'd0);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      idle();
      for (int l = 0; l < LN; l++) begin
        issue[l]          = ($urandom_range(0, 2) != 0);
        issueDstValid[l]  = ($urandom_range(0, 3) != 0);
        issueDstRegNum[l] = RW'($urandom);
        issueLatency[l]   = LW'($urandom_range(0, 6));
      end
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 24) == 0);
      rst   = ($urandom_range(0, 59) == 0);
      step("rand");
    end

    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

endmodule
